// File: rtl/core_ibex_dii_pkg.sv
// Shared types and default sizing for the DII responder slice.
package core_ibex_dii_pkg;

    typedef logic [31:0] dii_instr_t;

    localparam int unsigned DiiFifoDepthDefault   = 4;
    localparam int unsigned DiiMaxInflightDefault = 8;

endpackage

// File: rtl/core_ibex_dii_fifo.sv
// Synchronous FIFO holding injected instruction words; flush empties it in one cycle.
module core_ibex_dii_fifo
    import core_ibex_dii_pkg::*;
#(
    parameter  int unsigned Depth = DiiFifoDepthDefault,
    localparam int unsigned AW    = $clog2(Depth)
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        push_i,
    input  dii_instr_t  data_i,
    input  logic        pop_i,
    input  logic        flush_i,
    output dii_instr_t  data_o,
    output logic        full_o,
    output logic        empty_o,
    output logic [AW:0] level_o
);

    dii_instr_t      r_mem [Depth];
    logic [AW-1:0]   r_wptr;
    logic [AW-1:0]   r_rptr;
    logic [AW:0]     r_level;
    logic            w_push;
    logic            w_pop;

    assign full_o  = (r_level == (AW+1)'(Depth));
    assign empty_o = (r_level == (AW+1)'(0));
    assign level_o = r_level;
    assign data_o  = r_mem[r_rptr];
    assign w_push  = push_i && !full_o;
    assign w_pop   = pop_i && !empty_o;

    // Storage, pointers and fill level; pointers wrap naturally because Depth is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(Depth); i++) begin
                r_mem[i] <= 32'h0000_0000;
            end
            r_wptr  <= AW'(0);
            r_rptr  <= AW'(0);
            r_level <= (AW+1)'(0);
        end else if (flush_i) begin
            r_wptr  <= AW'(0);
            r_rptr  <= AW'(0);
            r_level <= (AW+1)'(0);
        end else begin
            if (w_push) begin
                r_mem[r_wptr] <= data_i;
                r_wptr        <= r_wptr + AW'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + (AW+1)'(1);
                2'b01:   r_level <= r_level - (AW+1)'(1);
                default: r_level <= r_level;
            endcase
        end
    end

endmodule

// File: rtl/core_ibex_dii_responder.sv
// Answers the core's fetch bus from injected words, throttled by unretired-instruction count.
module core_ibex_dii_responder
    import core_ibex_dii_pkg::*;
#(
    parameter  int unsigned FifoDepth      = DiiFifoDepthDefault,
    parameter  int unsigned MaxOutstanding = 2,
    parameter  int unsigned MaxInflight    = DiiMaxInflightDefault,
    parameter  int unsigned StallTimeout   = 1000,
    localparam int unsigned IW             = $clog2(MaxInflight + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push_valid_i,
    input  logic [31:0]   push_data_i,
    output logic          push_ready_o,
    input  logic          instr_req_i,
    input  logic [31:0]   instr_addr_i,
    output logic          instr_gnt_o,
    output logic          instr_rvalid_o,
    output logic [31:0]   instr_rdata_o,
    output logic          instr_err_o,
    output logic          instr_ack_o,
    input  logic          rvfi_valid_i,
    input  logic          flush_i,
    output logic [31:0]   instr_in_o,
    output logic [31:0]   instr_out_o,
    output logic [IW-1:0] inflight_o,
    output logic          timeout_o,
    output logic          underflow_o
);

    localparam int unsigned OW = $clog2(MaxOutstanding + 1);
    localparam int unsigned SW = $clog2(StallTimeout + 1);
    localparam int unsigned LW = $clog2(FifoDepth) + 1;

    logic [OW-1:0] r_outstanding;
    logic [IW-1:0] r_inflight;
    logic [SW-1:0] r_stall_cnt;
    logic [31:0]   r_in_cnt;
    logic [31:0]   r_out_cnt;
    logic          r_timeout;
    logic          r_underflow;
    logic          r_rvalid;
    dii_instr_t    r_rdata;

    logic [OW-1:0] w_outstanding_nxt;
    logic [IW-1:0] w_inflight_nxt;
    logic [SW-1:0] w_stall_nxt;
    logic          w_timeout_nxt;
    logic          w_underflow_nxt;
    logic          w_full;
    logic          w_empty;
    logic          w_push;
    logic          w_serve;
    dii_instr_t    w_head;
    logic [LW-1:0] w_fifo_level;
    logic          w_unused;

    // Address and fill level are debug-only observations.
    assign w_unused = ^{instr_addr_i, w_fifo_level};

    assign push_ready_o   = !w_full && !flush_i;
    assign w_push         = push_valid_i && push_ready_o;
    assign instr_gnt_o    = instr_req_i && (r_outstanding < OW'(MaxOutstanding)) && !flush_i;
    assign w_serve        = (r_outstanding != OW'(0)) && !w_empty
                            && (r_inflight < IW'(MaxInflight)) && !flush_i;

    assign instr_rvalid_o = r_rvalid;
    assign instr_ack_o    = r_rvalid;
    assign instr_rdata_o  = r_rdata;
    assign instr_err_o    = 1'b0;
    assign instr_in_o     = r_in_cnt;
    assign instr_out_o    = r_out_cnt;
    assign inflight_o     = r_inflight;
    assign timeout_o      = r_timeout;
    assign underflow_o    = r_underflow;

    core_ibex_dii_fifo #(
        .Depth (FifoDepth)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (w_push),
        .data_i  (push_data_i),
        .pop_i   (w_serve),
        .flush_i (flush_i),
        .data_o  (w_head),
        .full_o  (w_full),
        .empty_o (w_empty),
        .level_o (w_fifo_level)
    );

    // Next values of the outstanding, inflight and stall trackers and the sticky flags.
    always_comb begin
        w_outstanding_nxt = r_outstanding;
        w_inflight_nxt    = r_inflight;
        w_stall_nxt       = r_stall_cnt;
        w_underflow_nxt   = r_underflow | (rvfi_valid_i && (r_inflight == IW'(0)));

        if (flush_i) begin
            w_outstanding_nxt = OW'(0);
        end else begin
            case ({instr_gnt_o, w_serve})
                2'b10:   w_outstanding_nxt = r_outstanding + OW'(1);
                2'b01:   w_outstanding_nxt = r_outstanding - OW'(1);
                default: w_outstanding_nxt = r_outstanding;
            endcase
        end

        // A retirement with nothing in flight is clamped at zero rather than wrapping.
        case ({w_serve, rvfi_valid_i})
            2'b10: w_inflight_nxt = r_inflight + IW'(1);
            2'b01: begin
                if (r_inflight == IW'(0)) begin
                    w_inflight_nxt = r_inflight;
                end else begin
                    w_inflight_nxt = r_inflight - IW'(1);
                end
            end
            default: w_inflight_nxt = r_inflight;
        endcase

        if ((r_outstanding != OW'(0)) && w_empty) begin
            if (r_stall_cnt == SW'(StallTimeout)) begin
                w_stall_nxt = r_stall_cnt;
            end else begin
                w_stall_nxt = r_stall_cnt + SW'(1);
            end
        end else begin
            w_stall_nxt = SW'(0);
        end

        w_timeout_nxt = r_timeout | (w_stall_nxt == SW'(StallTimeout));
    end

    // State registers and the one-cycle response stage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_outstanding <= OW'(0);
            r_inflight    <= IW'(0);
            r_stall_cnt   <= SW'(0);
            r_in_cnt      <= 32'd0;
            r_out_cnt     <= 32'd0;
            r_timeout     <= 1'b0;
            r_underflow   <= 1'b0;
            r_rvalid      <= 1'b0;
            r_rdata       <= 32'h0000_0000;
        end else begin
            r_outstanding <= w_outstanding_nxt;
            r_inflight    <= w_inflight_nxt;
            r_stall_cnt   <= w_stall_nxt;
            r_timeout     <= w_timeout_nxt;
            r_underflow   <= w_underflow_nxt;
            r_rvalid      <= w_serve;
            if (w_serve) begin
                r_rdata <= w_head;
            end
            if (w_push) begin
                r_in_cnt <= r_in_cnt + 32'd1;
            end
            if (rvfi_valid_i) begin
                r_out_cnt <= r_out_cnt + 32'd1;
            end
        end
    end

endmodule
